// File: rtl/nvram_upload_responder_pkg.sv
// ---------------------------------------------------------------------------
// nvram_pkg
// Shared definitions for the NVRAM upload responder slice:
//   - state_t       : responder FSM states
//   - OOR_DATA      : byte returned for out-of-range reads or abandoned grants
//   - DEF_*         : default geometry of the Defender CMOS RAM
// ---------------------------------------------------------------------------
package nvram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] OOR_DATA = 8'hFF;

   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_SIZE        = 256;
   localparam int DEF_DATA_W      = 4;
   localparam int DEF_GNT_TIMEOUT = 63;

endpackage

// File: rtl/nvram_upload_responder_if.sv
// ---------------------------------------------------------------------------
// nvram_upload_responder_if
// Bundles the hps_io upload handshake and the CMOS RAM second-port bus.
//   ioctl_upload, ioctl_rd, ioctl_addr : HPS -> responder
//   ioctl_din, ioctl_wait              : responder -> HPS
//   ram_req, ram_addr                  : responder -> RAM arbiter
//   ram_gnt, ram_q                     : RAM arbiter -> responder
// Modports: slave = responder view, master = HPS/arbiter view.
// ---------------------------------------------------------------------------
interface nvram_upload_responder_if
   import nvram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              ioctl_upload;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_din;
   logic              ioctl_wait;
   logic              ram_req;
   logic              ram_gnt;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, ram_gnt, ram_q,
      output ioctl_din, ioctl_wait, ram_req, ram_addr
   );

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, ram_gnt, ram_q,
      input  ioctl_din, ioctl_wait, ram_req, ram_addr
   );

endinterface

// File: rtl/nvram_upload_responder_dirty_tracker.sv
// ---------------------------------------------------------------------------
// nvram_dirty_tracker
// Remembers that the CMOS RAM has been written since the last full upload.
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   set              : CPU write into CMOS this cycle
//   clr              : final CMOS location fetched during an upload
//   dirty            : flag; set has priority over clr in the same cycle
// ---------------------------------------------------------------------------
module nvram_dirty_tracker (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic set,
   input  logic clr,
   output logic dirty
);

   // A write racing the last fetch must not be lost, so set wins.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)  dirty <= 1'b0;
      else if (set)  dirty <= 1'b1;
      else if (clr)  dirty <= 1'b0;
   end

endmodule

// File: rtl/nvram_upload_responder.sv
// ---------------------------------------------------------------------------
// nvram_upload_responder
// Services hps_io upload read strobes from the battery-backed CMOS RAM,
// stalling the HPS with ioctl_wait while it arbitrates for the RAM port.
//   clk_sys, reset_n : system clock, asynchronous active-low reset
//   bus (slave)      : ioctl upload handshake + CMOS RAM second port
//   cpu_cmos_we      : CPU write strobe into CMOS (marks NVRAM dirty)
//   nvram_dirty      : CMOS modified since the last complete upload
//   timeout_err      : sticky, a grant timed out during this session
// The interface ADDR_W/DATA_W must match this module's parameters.
// ---------------------------------------------------------------------------
module nvram_upload_responder
   import nvram_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int SIZE        = DEF_SIZE,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   nvram_upload_responder_if.slave  bus,
   input  logic                     cpu_cmos_we,
   output logic                     nvram_dirty,
   output logic                     timeout_err
);

   localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);

   state_t            state, state_d;
   logic [7:0]        din_d;
   logic              wait_d;
   logic              req_d;
   logic [ADDR_W-1:0] addr_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              terr_d;
   logic              upload_q;
   logic              addr_oor;
   logic              fetch_last;

   function automatic logic [7:0] zext_q(input logic [DATA_W-1:0] q);
      return 8'(q);
   endfunction

   // High address bits are checked as well so a huge address can never
   // alias back into the RAM through truncation.
   assign addr_oor = (bus.ioctl_addr >= 25'(SIZE)) || (|bus.ioctl_addr[24:ADDR_W]);

   assign fetch_last = (state == FETCH) && bus.ioctl_upload &&
                       (bus.ram_addr == ADDR_W'(SIZE - 1));

   always_comb begin
      state_d = state;
      din_d   = bus.ioctl_din;
      wait_d  = bus.ioctl_wait;
      req_d   = bus.ram_req;
      addr_d  = bus.ram_addr;
      cnt_d   = cnt;
      terr_d  = timeout_err;

      if (bus.ioctl_upload && !upload_q) terr_d = 1'b0;

      if (!bus.ioctl_upload) begin
         // Session aborted: release the RAM and the HPS, keep last data.
         state_d = IDLE;
         req_d   = 1'b0;
         wait_d  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ioctl_rd) begin
                  wait_d = 1'b1;
                  if (addr_oor) begin
                     din_d   = OOR_DATA;
                     state_d = DONE;
                  end else begin
                     addr_d  = bus.ioctl_addr[ADDR_W-1:0];
                     req_d   = 1'b1;
                     cnt_d   = '0;
                     state_d = REQ;
                  end
               end
            end
            REQ: begin
               if (bus.ram_gnt) begin
                  req_d   = 1'b0;
                  state_d = FETCH;
               end else if (cnt == CNT_W'(GNT_TIMEOUT - 1)) begin
                  // Gives up on the GNT_TIMEOUT-th ungranted cycle.
                  req_d   = 1'b0;
                  din_d   = OOR_DATA;
                  terr_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            FETCH: begin
               din_d   = zext_q(bus.ram_q);
               state_d = DONE;
            end
            DONE: begin
               wait_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         bus.ioctl_din  <= 8'h00;
         bus.ioctl_wait <= 1'b0;
         bus.ram_req    <= 1'b0;
         bus.ram_addr   <= '0;
         cnt            <= '0;
         timeout_err    <= 1'b0;
         upload_q       <= 1'b0;
      end else begin
         state          <= state_d;
         bus.ioctl_din  <= din_d;
         bus.ioctl_wait <= wait_d;
         bus.ram_req    <= req_d;
         bus.ram_addr   <= addr_d;
         cnt            <= cnt_d;
         timeout_err    <= terr_d;
         upload_q       <= bus.ioctl_upload;
      end
   end

   nvram_dirty_tracker u_dirty (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .set     (cpu_cmos_we),
      .clr     (fetch_last),
      .dirty   (nvram_dirty)
   );

endmodule

// File: tb/tb_nvram_upload_responder.sv
// ---------------------------------------------------------------------------
// tb_nvram_upload_responder
// Self-checking bench for nvram_upload_responder: a directed vector table,
// hand-written multi-cycle sequences, and randomized reads checked against
// a transaction-level reference model. A small arbiter model returns
// mem[ram_addr] one cycle after the grant and random noise otherwise.
// ---------------------------------------------------------------------------
module tb_nvram_upload_responder;
   import nvram_pkg::*;

   localparam int ADDR_W      = 8;
   localparam int SIZE        = 256;
   localparam int DATA_W      = 4;
   localparam int GNT_TIMEOUT = 63;

   logic clk_sys = 1'b0;
   logic reset_n;
   logic cpu_cmos_we;
   logic nvram_dirty;
   logic timeout_err;

   nvram_upload_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   nvram_upload_responder #(
      .ADDR_W(ADDR_W), .SIZE(SIZE), .DATA_W(DATA_W), .GNT_TIMEOUT(GNT_TIMEOUT)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .bus         (bus),
      .cpu_cmos_we (cpu_cmos_we),
      .nvram_dirty (nvram_dirty),
      .timeout_err (timeout_err)
   );

   always #5 clk_sys = ~clk_sys;

   logic [DATA_W-1:0] mem [SIZE];

   always @(posedge clk_sys) begin
      if (bus.ram_req && bus.ram_gnt) bus.ram_q <= mem[bus.ram_addr];
      else                            bus.ram_q <= DATA_W'($urandom);
   end

   int n_checks = 0;
   int n_fail   = 0;
   int gnt_delay;
   int req_seen;
   bit exp_dirty;
   bit exp_terr;

   typedef struct {
      logic [24:0] addr;
      int          delay;
      logic [7:0]  din;
      int          wcyc;
      int          rcyc;
      bit          terr;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock; the arbiter grants once ram_req has been seen gnt_delay times.
   task automatic step();
      @(negedge clk_sys);
      if (bus.ram_req) begin
         req_seen++;
         bus.ram_gnt = (req_seen > gnt_delay);
      end else begin
         bus.ram_gnt = 1'b0;
      end
   endtask

   task automatic pulse_we();
      cpu_cmos_we = 1'b1;
      step();
      cpu_cmos_we = 1'b0;
      exp_dirty = 1'b1;
   endtask

   task automatic do_read(input logic [24:0] a, input int d, input logic [7:0] e_din,
                          input int e_wait, input int e_req, input bit e_terr,
                          input string nm);
      int wcnt;
      int rcnt;
      bit addr_ok;
      bus.ioctl_addr = a;
      bus.ioctl_rd   = 1'b1;
      gnt_delay      = d;
      req_seen       = 0;
      step();
      bus.ioctl_rd = 1'b0;
      wcnt = 0;
      rcnt = 0;
      addr_ok = 1'b1;
      while (bus.ioctl_wait && wcnt < 300) begin
         wcnt++;
         if (bus.ram_req) begin
            rcnt++;
            if (bus.ram_addr !== a[ADDR_W-1:0]) addr_ok = 1'b0;
         end
         step();
      end
      chk({nm, "_wait_cycles"}, wcnt, e_wait);
      chk({nm, "_req_cycles"}, rcnt, e_req);
      chk({nm, "_addr_stable"}, addr_ok, 1);
      chk({nm, "_din"}, bus.ioctl_din, e_din);
      chk({nm, "_req_end"}, bus.ram_req, 0);
      chk({nm, "_terr"}, timeout_err, e_terr);
      step();
      chk({nm, "_din_hold"}, bus.ioctl_din, e_din);
   endtask

   // Transaction-level expectation for a single upload read.
   function automatic void model(input logic [24:0] a, input int d, output logic [7:0] din,
                                 output int w, output int r, output bit to);
      to = 1'b0;
      if (a >= SIZE) begin
         din = 8'hFF; w = 1; r = 0;
      end else if (d >= GNT_TIMEOUT) begin
         din = 8'hFF; w = GNT_TIMEOUT + 1; r = GNT_TIMEOUT; to = 1'b1;
      end else begin
         din = 8'(mem[a[ADDR_W-1:0]]); w = d + 3; r = d + 1;
      end
   endfunction

   task automatic do_read_model(input logic [24:0] a, input int d, input string nm);
      logic [7:0] e_din;
      int e_w;
      int e_r;
      bit to;
      model(a, d, e_din, e_w, e_r, to);
      if (to) exp_terr = 1'b1;
      if (!to && a == 25'(SIZE - 1)) exp_dirty = 1'b0;
      do_read(a, d, e_din, e_w, e_r, exp_terr, nm);
      chk({nm, "_dirty"}, nvram_dirty, exp_dirty);
   endtask

   initial begin
      int n;
      logic [24:0] a;
      int d;

      for (int i = 0; i < SIZE; i++) mem[i] = DATA_W'((i * 7 + 3) % 16);
      mem[16] = 4'hA;

      vecs[0] = '{25'h10,      0,  8'h0A, 3,  1,  1'b0};
      vecs[1] = '{25'h20,      5,  8'h03, 8,  6,  1'b0};
      vecs[2] = '{25'h100,     0,  8'hFF, 1,  0,  1'b0};
      vecs[3] = '{25'h1000000, 0,  8'hFF, 1,  0,  1'b0};
      vecs[4] = '{25'hFF,      2,  8'h0C, 5,  3,  1'b0};
      vecs[5] = '{25'h00,      62, 8'h03, 65, 63, 1'b0};
      vecs[6] = '{25'h05,      63, 8'hFF, 64, 63, 1'b1};
      vecs[7] = '{25'h0FFFF00, 0,  8'hFF, 1,  0,  1'b1};

      reset_n          = 1'b0;
      cpu_cmos_we      = 1'b0;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      bus.ram_gnt      = 1'b0;
      gnt_delay        = 0;
      req_seen         = 0;
      exp_dirty        = 1'b0;
      exp_terr         = 1'b0;

      step();
      chk("rst_din", bus.ioctl_din, 8'h00);
      chk("rst_wait", bus.ioctl_wait, 0);
      chk("rst_req", bus.ram_req, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_dirty", nvram_dirty, 0);
      chk("rst_terr", timeout_err, 0);

      reset_n = 1'b1;
      step();
      bus.ioctl_upload = 1'b1;
      step();

      for (int i = 0; i < 8; i++)
         do_read(vecs[i].addr, vecs[i].delay, vecs[i].din, vecs[i].wcyc,
                 vecs[i].rcyc, vecs[i].terr, $sformatf("vec%0d", i));
      exp_terr = 1'b1;

      // Abort while waiting for a grant that never comes.
      bus.ioctl_addr = 25'h30;
      bus.ioctl_rd   = 1'b1;
      gnt_delay      = 1000;
      req_seen       = 0;
      step();
      bus.ioctl_rd = 1'b0;
      step();
      step();
      chk("abort_pre_req", bus.ram_req, 1);
      bus.ioctl_upload = 1'b0;
      step();
      chk("abort_req", bus.ram_req, 0);
      chk("abort_wait", bus.ioctl_wait, 0);
      chk("abort_din", bus.ioctl_din, 8'hFF);
      bus.ioctl_upload = 1'b1;
      step();
      chk("rise_terr_clear", timeout_err, 0);
      exp_terr = 1'b0;
      do_read_model(25'h40, 1, "post_abort");

      // Full sweep: dirty must survive until the last location is fetched.
      for (int i = 0; i < SIZE; i++) mem[i] = DATA_W'($urandom);
      pulse_we();
      chk("we_dirty", nvram_dirty, 1);
      for (int i = 0; i < SIZE; i++)
         do_read_model(25'(i), $urandom_range(0, 3), $sformatf("sweep%0d", i));
      chk("sweep_dirty_clear", nvram_dirty, 0);

      // CPU write coincident with the final fetch keeps the flag set.
      bus.ioctl_addr = 25'hFF;
      bus.ioctl_rd   = 1'b1;
      gnt_delay      = 0;
      req_seen       = 0;
      step();
      bus.ioctl_rd = 1'b0;
      step();
      cpu_cmos_we = 1'b1;
      step();
      cpu_cmos_we = 1'b0;
      exp_dirty = 1'b1;
      chk("coinc_dirty", nvram_dirty, 1);
      n = 0;
      while (bus.ioctl_wait && n < 10) begin
         n++;
         step();
      end
      chk("coinc_wait_fall", bus.ioctl_wait, 0);
      chk("coinc_din", bus.ioctl_din, 8'(mem[255]));
      step();
      chk("coinc_dirty_hold", nvram_dirty, 1);

      // Randomized reads against the reference model.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) a = 25'($urandom);
         else                           a = 25'($urandom_range(0, SIZE - 1));
         if ($urandom_range(0, 9) == 0) d = GNT_TIMEOUT + $urandom_range(0, 5);
         else                           d = $urandom_range(0, 10);
         if ($urandom_range(0, 2) == 0) pulse_we();
         do_read_model(a, d, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a fetch.
      do_read_model(25'h22, 70, "pre_rst_to");
      pulse_we();
      bus.ioctl_addr = 25'h10;
      bus.ioctl_rd   = 1'b1;
      gnt_delay      = 0;
      req_seen       = 0;
      step();
      bus.ioctl_rd = 1'b0;
      step();
      chk("pre_rst_terr", timeout_err, 1);
      chk("pre_rst_dirty", nvram_dirty, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_din", bus.ioctl_din, 8'h00);
      chk("arst_wait", bus.ioctl_wait, 0);
      chk("arst_req", bus.ram_req, 0);
      chk("arst_addr", bus.ram_addr, 0);
      chk("arst_dirty", nvram_dirty, 0);
      chk("arst_terr", timeout_err, 0);
      step();
      reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
